// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus field widths and the slave control states.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_slave_state_e;

endpackage

// File: rtl/wb_slave_bus_t.sv
// Wishbone classic bus bundle; the slave modport is what a memory responder sees.
interface wb_slave_bus_t;
  import wb_pkg::*;

  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_ms;
  logic                we;
  logic [WB_SEL_W-1:0] sel;
  logic                stb;
  logic                cyc;
  logic [WB_DAT_W-1:0] dat_sm;
  logic                ack;
  logic                err;

  modport slave (
    input  adr, dat_ms, we, sel, stb, cyc,
    output dat_sm, ack, err
  );

  modport master (
    output adr, dat_ms, we, sel, stb, cyc,
    input  dat_sm, ack, err
  );

endinterface

// File: rtl/sp_ram.sv
// Single-port DEPTHx32 synchronous RAM with per-byte write enables and a
// registered, read-first output; no reset so it maps onto block RAM.
module sp_ram
  import wb_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic                     we_i,
  input  logic [WB_SEL_W-1:0]      be_i,
  input  logic [WB_DAT_W-1:0]      wdata_i,
  output logic [WB_DAT_W-1:0]      rdata_o
);

  logic [WB_DAT_W-1:0] mem_q [DEPTH];
  logic [WB_DAT_W-1:0] rdata_q;

  // Read every cycle; write only the enabled byte lanes
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr_i];
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave fronting the on-chip data RAM with LATENCY wait states.
// Optional out-of-range error response: define WB_RAM_ADDR_ERR_EN.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic          clk,
  input  logic          rstn_i,
  wb_slave_bus_t.slave  wb_bus
);

  localparam int AW = $clog2(DEPTH);

  wb_slave_state_e     state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [WB_DAT_W-1:0] wdat_q, wdat_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic                oor_q, oor_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;

  logic                req_s;
  logic                oor_s;
  logic [AW-1:0]       ram_addr_s;
  logic                ram_we_s;
  logic [WB_DAT_W-1:0] ram_rdata_s;
  logic                unused_s;

  assign req_s = wb_bus.cyc & wb_bus.stb;

`ifdef WB_RAM_ADDR_ERR_EN
  assign oor_s    = (32'(wb_bus.adr[31:2]) >= 32'(DEPTH));
  assign unused_s = ^wb_bus.adr[1:0];
`else
  // Upper bits are dropped so out-of-range addresses alias modulo DEPTH
  assign oor_s    = 1'b0;
  assign unused_s = ^{wb_bus.adr[31:AW+2], wb_bus.adr[1:0]};
`endif

  // Next-state, request capture and wait-state counting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          idx_d  = wb_bus.adr[AW+1:2];
          wdat_d = wb_bus.dat_ms;
          we_d   = wb_bus.we;
          sel_d  = wb_bus.sel;
          oor_d  = oor_s;
          cnt_d  = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!wb_bus.cyc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    ack_d = (state_d == ACK) && !oor_d;
    err_d = (state_d == ACK) && oor_d;
  end

  // State, captured request and response flags
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // In IDLE the live address feeds the RAM so a zero-latency read lands in ACK
  assign ram_addr_s = (state_q == IDLE) ? wb_bus.adr[AW+1:2] : idx_q;
  assign ram_we_s   = (state_q == ACK) && we_q && !oor_q;

  sp_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr_s),
    .we_i    (ram_we_s),
    .be_i    (sel_q),
    .wdata_i (wdat_q),
    .rdata_o (ram_rdata_s)
  );

  assign wb_bus.ack    = ack_q;
  assign wb_bus.err    = err_q;
  assign wb_bus.dat_sm = (ack_q && !we_q) ? ram_rdata_s : 32'd0;

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone classic slave that services the load/store unit's bus cycles from a single-port on-chip data RAM. It is the responder at the far end of `wb_bus`: it accepts one request per bus cycle and applies byte-lane writes from `sel`. It returns read data with a registered `ack` after a configurable number of wait states. It sits in the SoC memory map as the core's data memory.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 0: wait states inserted between request acceptance and `ack`; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- wb_bus  slave  -  `wb_slave_bus_t`. The block uses these fields:
  - adr: 32, in.
  - dat_ms: 32, in, write data.
  - we: 1, in.
  - sel: 4, in.
  - stb: 1, in.
  - cyc: 1, in.
  - dat_sm: 32, out, read data.
  - ack: 1, out.
  - err: 1, out.

## Operation
- States:
  - IDLE: no request in progress.
  - WAIT: counting wait states.
  - ACK: `ack` or `err` high.
- Request = `cyc & stb` sampled high in IDLE.
  - On the accepting edge, latch adr, dat_ms, we and sel; load the wait counter with LATENCY.
  - If LATENCY==0, go directly to ACK; otherwise go to WAIT.
- WAIT: decrement the counter each cycle; at 1, go to ACK.
- ACK: `ack`=1 for exactly one cycle, then go to IDLE unconditionally.
- Word index = latched adr[$clog2(DEPTH)+1:2]; adr[1:0] is ignored.
- Writes (we=1):
  - Byte lane i is written iff sel[i].
  - The write commits on the edge that leaves ACK. The RAM is unchanged before that edge.
  - sel=0000 still acks and writes nothing.
  - dat_sm = 0 during a write ack.
- Reads (we=0):
  - dat_sm = full word at the index, valid only while `ack`=1; sel is ignored.
  - dat_sm = 0 whenever `ack`=0.
- Abort: if `cyc` is low during any WAIT cycle, go to IDLE. No ack, no write.
- `cyc` dropping during ACK does not cancel the transfer; the write still commits.
- stb held high after ack: it is treated as a new request on the next IDLE cycle.
- No back-to-back: minimum spacing is one IDLE cycle between acks.
- Reset mid-operation:
  - State returns to IDLE; ack, err and dat_sm go to 0 immediately.
  - A pending write is discarded.
  - RAM contents are not reset.

## Timing
- Reset values: ack=0, err=0, dat_sm=0, state=IDLE, counter=0.
- Request sampled at edge N → `ack` high in the cycle after edge N+LATENCY.
  - LATENCY=0: ack in the cycle immediately after acceptance.
- Throughput: one transfer per LATENCY+2 cycles with stb held high.
- All outputs are registered. There is no combinational path from bus inputs to ack/err/dat_sm.

## Configuration
- `WB_RAM_ADDR_ERR_EN` defined:
  - An address with adr[31:2] ≥ DEPTH is out of range.
  - It is acknowledged with `err`=1 instead of `ack`, with the same timing.
  - No write, dat_sm=0.
- Not defined:
  - `err` is tied to 0.
  - Upper address bits are ignored, so out-of-range accesses alias modulo DEPTH and ack normally.

## Structure
- Shared package `wb_pkg`:
  - `wb_slave_state_e` {IDLE, WAIT, ACK}.
  - Field width constants: WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
- Sub-module `sp_ram`:
  - Single-port synchronous RAM, DEPTH×32.
  - Per-byte write enable, registered read.
  - Parameterised on DEPTH. This keeps the array inferable as block RAM.
  - Its read is issued so that data is valid in the ACK cycle.
- Control FSM and counter live in `wb_ram_slave`.

## Test plan
- Reset, then read word 0 with LATENCY=0 → ack exactly one cycle after acceptance, dat_sm=0 outside the ack cycle.
- Write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10 → 0xDEADBEEF. Then write 0x000000AA with sel=0001 and read back → 0xDEADBEAA.
- LATENCY=3, write then read 0x20 → each ack arrives 4 cycles after acceptance and spacing between acks is 5 cycles.
- LATENCY=3, write 0x11111111 to 0x30, drop cyc in the second WAIT cycle → no ack. A subsequent read of 0x30 returns its previous value.
- Assert rstn_i low during WAIT of a write → ack stays 0, state returns to IDLE, RAM unchanged.
- DEPTH=1024, read adr=0x00001004:
  - With `WB_RAM_ADDR_ERR_EN`: err=1, ack=0, dat_sm=0.
  - Without it: ack=1 and the data returned is that of 0x004.
